// File: rtl/sram_like_axi_pkg.sv
// Shared types and AXI constants for the sram-like to AXI3 responder.
package sram_like_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;
    localparam logic [3:0] CACHE_ZERO = 4'd0;
    localparam logic [2:0] PROT_ZERO  = 3'd0;
    localparam logic [1:0] LOCK_ZERO  = 2'd0;

    // Byte-lane strobes for a single beat, addr_lo is addr[1:0].
    function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd0:    return 4'b0001 << addr_lo;
            2'd1:    return 4'b0011 << {addr_lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sram_like_to_axi_if.sv
// Bundle of the sram-like request port and the AXI3 master port.
interface sram_like_to_axi_if;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    logic [3:0]  arid;   logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
    logic [1:0]  arburst; logic [1:0] arlock; logic [3:0] arcache; logic [2:0] arprot;
    logic        arvalid, arready;

    logic [3:0]  rid;    logic [31:0] rdata_axi; logic [1:0] rresp;
    logic        rlast, rvalid, rready;

    logic [3:0]  awid;   logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
    logic [1:0]  awburst; logic [1:0] awlock; logic [3:0] awcache; logic [2:0] awprot;
    logic        awvalid, awready;

    logic [3:0]  wid;    logic [31:0] wdata_axi; logic [3:0] wstrb;
    logic        wlast, wvalid, wready;

    logic [3:0]  bid;    logic [1:0] bresp;
    logic        bvalid, bready;

    logic        bus_err;

    // Responder side: serves sram-like requests, masters AXI.
    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata_axi, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata_axi, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output bus_err
    );

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata_axi, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata_axi, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  bus_err
    );
endinterface

// File: rtl/sram_like_to_axi.sv
// Single-outstanding sram-like to AXI3 single-beat bridge.
// Optional sticky response error flag: define SRAM_LIKE_AXI_ERR_EN.
module sram_like_to_axi
    import sram_like_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic               clk,
    input  logic               resetn,
    sram_like_to_axi_if.slave  bus
);

    state_t      state;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic        aw_done, w_done;

    wire aw_fire = awvalid_q & bus.awready;
    wire w_fire  = wvalid_q  & bus.wready;
    wire r_fire  = rready_q  & bus.rvalid;
    wire b_fire  = bready_q  & bus.bvalid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.req) begin
                    // size 3 is folded to word here so AXI never sees a 64-bit beat
                    size_q  <= (bus.size == 2'd3) ? 2'd2 : bus.size;
                    addr_q  <= bus.addr;
                    wdata_q <= bus.wdata;
                    if (bus.wr) begin
                        state     <= S_AW_W;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                    end else begin
                        state     <= S_AR;
                        arvalid_q <= 1'b1;
                    end
                end
                S_AR: if (bus.arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state     <= S_R;
                end
                S_R: if (bus.rvalid) begin
                    rready_q <= 1'b0;
                    state    <= S_IDLE;
                end
                S_AW_W: begin
                    if (aw_fire) begin awvalid_q <= 1'b0; aw_done <= 1'b1; end
                    if (w_fire)  begin wvalid_q  <= 1'b0; w_done  <= 1'b1; end
                    if ((aw_done | aw_fire) && (w_done | w_fire)) begin
                        bready_q <= 1'b1;
                        state    <= S_B;
                    end
                end
                S_B: if (bus.bvalid) begin
                    bready_q <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SRAM_LIKE_AXI_ERR_EN
    logic bus_err_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            bus_err_q <= 1'b0;
        else if ((r_fire && bus.rresp != 2'b00) || (b_fire && bus.bresp != 2'b00))
            bus_err_q <= 1'b1;
    end
    assign bus.bus_err = bus_err_q;
`else
    assign bus.bus_err = 1'b0;
`endif

    // Only one transaction in flight, so IDs and rlast carry no information.
    logic unused_ok;
    assign unused_ok = ^{bus.rid, bus.bid, bus.rlast, bus.rresp, bus.bresp};

    assign bus.addr_ok = (state == S_IDLE);
    assign bus.data_ok = r_fire | b_fire;
    assign bus.rdata   = r_fire ? bus.rdata_axi : 32'd0;

    assign bus.arid    = AXI_ID;
    assign bus.araddr  = addr_q;
    assign bus.arlen   = LEN_SINGLE;
    assign bus.arsize  = {1'b0, size_q};
    assign bus.arburst = BURST_INCR;
    assign bus.arlock  = LOCK_ZERO;
    assign bus.arcache = CACHE_ZERO;
    assign bus.arprot  = PROT_ZERO;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;

    assign bus.awid    = AXI_ID;
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = LEN_SINGLE;
    assign bus.awsize  = {1'b0, size_q};
    assign bus.awburst = BURST_INCR;
    assign bus.awlock  = LOCK_ZERO;
    assign bus.awcache = CACHE_ZERO;
    assign bus.awprot  = PROT_ZERO;
    assign bus.awvalid = awvalid_q;

    assign bus.wid       = AXI_ID;
    assign bus.wdata_axi = wdata_q;
    assign bus.wstrb     = gen_wstrb(size_q, addr_q[1:0]);
    assign bus.wlast     = 1'b1;
    assign bus.wvalid    = wvalid_q;
    assign bus.bready    = bready_q;

endmodule

// File: tb/tb_sram_like_to_axi.sv
// Directed self-checking bench for sram_like_to_axi.
module tb_sram_like_to_axi;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sram_like_to_axi_if bus();

    sram_like_to_axi #(.AXI_ID(4'd0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc;
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs;
        bus.req = 0; bus.wr = 0; bus.size = 0; bus.addr = 0; bus.wdata = 0;
        bus.arready = 0; bus.rid = 0; bus.rdata_axi = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        resetn = 0;
        cyc(); cyc();
        resetn = 1;
        @(negedge clk);
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("FAIL reset_addr_ok got %b exp 1", bus.addr_ok); end
        checks++; if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0) begin
            errors++; $display("FAIL reset_valids got %b exp 00000", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}); end
        checks++; if ({bus.data_ok, bus.bus_err} !== 2'b00) begin errors++; $display("FAIL reset_dok_err got %b exp 00", {bus.data_ok, bus.bus_err}); end
        checks++; if (bus.araddr !== 32'd0 || bus.wdata_axi !== 32'd0 || bus.arsize !== 3'd0) begin
            errors++; $display("FAIL reset_latches got %h/%h/%h exp 0/0/0", bus.araddr, bus.wdata_axi, bus.arsize); end
        cyc();
    endtask

    task automatic test_word_read;
        bus.req = 1; bus.wr = 0; bus.size = 2; bus.addr = 32'h1FC0_0000;
        @(negedge clk);
        checks++; if (bus.addr_ok !== 1'b1) begin errors++; $display("FAIL rd_addr_ok got %b exp 1", bus.addr_ok); end
        cyc();
        bus.req = 0; bus.addr = 32'hFFFF_FFFF; bus.arready = 1;
        @(negedge clk);
        checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h1FC0_0000) begin
            errors++; $display("FAIL rd_ar got v=%b a=%h exp v=1 a=1fc00000", bus.arvalid, bus.araddr); end
        checks++; if (bus.arsize !== 3'b010 || bus.arlen !== 8'd0 || bus.arburst !== 2'b01 || bus.arid !== 4'd0) begin
            errors++; $display("FAIL rd_ar_fields got sz=%b len=%h bu=%b id=%h exp 010/00/01/0", bus.arsize, bus.arlen, bus.arburst, bus.arid); end
        checks++; if (bus.addr_ok !== 1'b0 || bus.data_ok !== 1'b0) begin
            errors++; $display("FAIL rd_busy got aok=%b dok=%b exp 0/0", bus.addr_ok, bus.data_ok); end
        cyc();
        bus.arready = 0; bus.rvalid = 1; bus.rdata_axi = 32'h3C08_0001;
        @(negedge clk);
        checks++; if (bus.data_ok !== 1'b1 || bus.rdata !== 32'h3C08_0001) begin
            errors++; $display("FAIL rd_data got dok=%b d=%h exp 1/3c080001", bus.data_ok, bus.rdata); end
        checks++; if (bus.arvalid !== 1'b0 || bus.rready !== 1'b1) begin
            errors++; $display("FAIL rd_r_phase got arv=%b rr=%b exp 0/1", bus.arvalid, bus.rready); end
        cyc();
        bus.rvalid = 0;
        @(negedge clk);
        checks++; if (bus.data_ok !== 1'b0 || bus.rdata !== 32'd0 || bus.addr_ok !== 1'b1 || bus.rready !== 1'b0) begin
            errors++; $display("FAIL rd_done got dok=%b d=%h aok=%b rr=%b exp 0/0/1/0", bus.data_ok, bus.rdata, bus.addr_ok, bus.rready); end
    endtask

    task automatic test_byte_write;
        bus.req = 1; bus.wr = 1; bus.size = 0; bus.addr = 32'h8000_0003; bus.wdata = 32'hAB00_0000;
        cyc();
        bus.req = 0; bus.wdata = 32'h0; bus.awready = 1; bus.wready = 1;
        @(negedge clk);
        checks++; if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1) begin
            errors++; $display("FAIL wr_valids got aw=%b w=%b exp 1/1", bus.awvalid, bus.wvalid); end
        checks++; if (bus.wstrb !== 4'b1000 || bus.awaddr !== 32'h8000_0003 || bus.wdata_axi !== 32'hAB00_0000) begin
            errors++; $display("FAIL wr_payload got st=%b a=%h d=%h exp 1000/80000003/ab000000", bus.wstrb, bus.awaddr, bus.wdata_axi); end
        checks++; if (bus.awsize !== 3'b000 || bus.wlast !== 1'b1 || bus.awburst !== 2'b01 || bus.awlen !== 8'd0) begin
            errors++; $display("FAIL wr_fields got sz=%b wl=%b bu=%b len=%h exp 000/1/01/00", bus.awsize, bus.wlast, bus.awburst, bus.awlen); end
        cyc();
        bus.awready = 0; bus.wready = 0;
        @(negedge clk);
        checks++; if (bus.bready !== 1'b1 || bus.data_ok !== 1'b0 || bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0) begin
            errors++; $display("FAIL wr_b_wait got br=%b dok=%b aw=%b w=%b exp 1/0/0/0", bus.bready, bus.data_ok, bus.awvalid, bus.wvalid); end
        cyc();
        bus.bvalid = 1;
        @(negedge clk);
        checks++; if (bus.data_ok !== 1'b1 || bus.rdata !== 32'd0) begin
            errors++; $display("FAIL wr_dok got dok=%b rd=%h exp 1/0", bus.data_ok, bus.rdata); end
        cyc();
        bus.bvalid = 0;
        @(negedge clk);
        checks++; if (bus.data_ok !== 1'b0 || bus.addr_ok !== 1'b1) begin
            errors++; $display("FAIL wr_done got dok=%b aok=%b exp 0/1", bus.data_ok, bus.addr_ok); end
    endtask

    task automatic test_staggered_write;
        int dok_cnt;
        bit got;
        dok_cnt = 0;
        bus.req = 1; bus.wr = 1; bus.size = 1; bus.addr = 32'h0000_0102; bus.wdata = 32'h5678_0000;
        cyc();
        bus.req = 0; bus.awready = 1;
        @(negedge clk);
        checks++; if (bus.wstrb !== 4'b1100 || bus.awsize !== 3'b001) begin
            errors++; $display("FAIL stg_half got st=%b sz=%b exp 1100/001", bus.wstrb, bus.awsize); end
        cyc();
        bus.awready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.wready = 1;
            @(negedge clk);
            checks++; if (bus.awvalid !== 1'b0 || bus.wvalid !== 1'b1 || bus.data_ok !== 1'b0) begin
                errors++; $display("FAIL stg_hold%0d got aw=%b w=%b dok=%b exp 0/1/0", i, bus.awvalid, bus.wvalid, bus.data_ok); end
            cyc();
        end
        bus.wready = 0;
        @(negedge clk);
        checks++; if (bus.wvalid !== 1'b0 || bus.bready !== 1'b1) begin
            errors++; $display("FAIL stg_b got w=%b br=%b exp 0/1", bus.wvalid, bus.bready); end
        cyc();
        bus.bvalid = 1;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.data_ok) dok_cnt++;
            cyc();
            bus.bvalid = 0;
        end
        checks++; if (dok_cnt !== 1) begin errors++; $display("FAIL stg_dok_count got %0d exp 1", dok_cnt); end
    endtask

    task automatic test_backpressure;
        bus.req = 1; bus.wr = 0; bus.size = 3; bus.addr = 32'h0000_0040;
        cyc();
        for (int i = 0; i < 5; i++) begin
            bus.addr = 32'hA000_0000 + i * 4;
            @(negedge clk);
            checks++; if (bus.araddr !== 32'h0000_0040 || bus.addr_ok !== 1'b0 || bus.arvalid !== 1'b1 || bus.arsize !== 3'b010) begin
                errors++; $display("FAIL bp_hold%0d got a=%h aok=%b v=%b sz=%b exp 00000040/0/1/010", i, bus.araddr, bus.addr_ok, bus.arvalid, bus.arsize); end
            cyc();
        end
        bus.req = 0; bus.arready = 1;
        cyc();
        bus.arready = 0; bus.rvalid = 1; bus.rdata_axi = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (bus.data_ok !== 1'b1 || bus.rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL bp_data got dok=%b d=%h exp 1/deadbeef", bus.data_ok, bus.rdata); end
        cyc();
        bus.rvalid = 0;
    endtask

    task automatic test_reset_in_r;
        bus.req = 1; bus.wr = 0; bus.size = 2; bus.addr = 32'h0000_0200;
        cyc();
        bus.req = 0; bus.arready = 1;
        cyc();
        bus.arready = 0;
        @(negedge clk);
        checks++; if (bus.rready !== 1'b1) begin errors++; $display("FAIL rst_r_setup got rr=%b exp 1", bus.rready); end
        cyc();
        resetn = 0; bus.rvalid = 1; bus.rdata_axi = 32'h1111_2222;
        @(negedge clk);
        checks++; if (bus.data_ok !== 1'b0 || bus.rdata !== 32'd0 || {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0) begin
            errors++; $display("FAIL rst_abort got dok=%b d=%h v=%b exp 0/0/00000", bus.data_ok, bus.rdata,
                {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}); end
        cyc();
        resetn = 1;
        @(negedge clk);
        checks++; if (bus.addr_ok !== 1'b1 || bus.data_ok !== 1'b0 || bus.rready !== 1'b0) begin
            errors++; $display("FAIL rst_after got aok=%b dok=%b rr=%b exp 1/0/0", bus.addr_ok, bus.data_ok, bus.rready); end
        cyc();
        bus.rvalid = 0;
    endtask

    task automatic test_bus_err;
        logic exp_err;
`ifdef SRAM_LIKE_AXI_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        bus.req = 1; bus.wr = 1; bus.size = 2; bus.addr = 32'h0000_0300; bus.wdata = 32'hCAFE_F00D;
        cyc();
        bus.req = 0; bus.awready = 1; bus.wready = 1;
        cyc();
        bus.awready = 0; bus.wready = 0; bus.bvalid = 1; bus.bresp = 2'b10;
        @(negedge clk);
        checks++; if (bus.data_ok !== 1'b1) begin errors++; $display("FAIL err_dok got %b exp 1", bus.data_ok); end
        cyc();
        bus.bvalid = 0; bus.bresp = 0;
        @(negedge clk);
        checks++; if (bus.bus_err !== exp_err) begin errors++; $display("FAIL err_set got %b exp %b", bus.bus_err, exp_err); end
        for (int k = 0; k < 2; k++) begin
            bus.req = 1; bus.wr = 0; bus.addr = 32'h0000_0400 + k * 4;
            cyc();
            bus.req = 0; bus.arready = 1;
            cyc();
            bus.arready = 0; bus.rvalid = 1; bus.rresp = 0; bus.rdata_axi = 32'h0000_1000 + k;
            cyc();
            bus.rvalid = 0;
            @(negedge clk);
            checks++; if (bus.bus_err !== exp_err) begin errors++; $display("FAIL err_sticky%0d got %b exp %b", k, bus.bus_err, exp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        cyc();
        test_byte_write();
        cyc();
        test_staggered_write();
        test_backpressure();
        cyc();
        test_reset_in_r();
        test_bus_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
